// File: rtl/riscv_issue_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_issue_arb: two-requester round-robin issue arbiter with RAW         |
// | scoreboard, outstanding-ack tracking and IDLE/RUN/DRAIN control FSM.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module riscv_issue_arb #(
    parameter int REG_WIDTH  = 5,
    parameter int OP_WIDTH   = 7,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 req0_valid,
    input  logic [REG_WIDTH-1:0] req0_rs0,
    input  logic [REG_WIDTH-1:0] req0_rs1,
    input  logic [REG_WIDTH-1:0] req0_rd,
    input  logic [OP_WIDTH-1:0]  req0_opcode,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [REG_WIDTH-1:0] req1_rs0,
    input  logic [REG_WIDTH-1:0] req1_rs1,
    input  logic [REG_WIDTH-1:0] req1_rd,
    input  logic [OP_WIDTH-1:0]  req1_opcode,
    output logic                 req1_ready,
    output logic                 iss_valid,
    output logic [REG_WIDTH-1:0] iss_rs0,
    output logic [REG_WIDTH-1:0] iss_rs1,
    output logic [REG_WIDTH-1:0] iss_rd,
    output logic [OP_WIDTH-1:0]  iss_opcode,
    input  logic                 ack,
    output logic [1:0]           state,
    output logic                 busy,
    output logic                 err_ack
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 iss_valid_q, iss_valid_d;
    logic [REG_WIDTH-1:0] iss_rs0_q, iss_rs0_d;
    logic [REG_WIDTH-1:0] iss_rs1_q, iss_rs1_d;
    logic [REG_WIDTH-1:0] iss_rd_q, iss_rd_d;
    logic [OP_WIDTH-1:0]  iss_op_q, iss_op_d;
    logic [FIFO_DEPTH-1:0] shd_valid_q, shd_valid_d;
    logic [REG_WIDTH-1:0] shd_rd_q [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] shd_rd_d [FIFO_DEPTH];
    logic [CNT_W-1:0]     outst_q, outst_d;
    logic                 err_q, err_d;
    logic                 last_q, last_d;

    logic w_haz0, w_haz1, w_elig0, w_elig1, w_sb_empty;

    // x0 is never a real destination, so it can never create a RAW hazard.
    function automatic logic hit(input logic [REG_WIDTH-1:0] rs,
                                 input logic [REG_WIDTH-1:0] rd,
                                 input logic                 v);
        return v && (rd != '0) && (rs == rd);
    endfunction

    always_comb begin
        w_haz0 = hit(req0_rs0, iss_rd_q, iss_valid_q) | hit(req0_rs1, iss_rd_q, iss_valid_q);
        w_haz1 = hit(req1_rs0, iss_rd_q, iss_valid_q) | hit(req1_rs1, iss_rd_q, iss_valid_q);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_haz0 = w_haz0 | hit(req0_rs0, shd_rd_q[i], shd_valid_q[i])
                            | hit(req0_rs1, shd_rd_q[i], shd_valid_q[i]);
            w_haz1 = w_haz1 | hit(req1_rs0, shd_rd_q[i], shd_valid_q[i])
                            | hit(req1_rs1, shd_rd_q[i], shd_valid_q[i]);
        end
    end

    assign w_elig0    = req0_valid & ~w_haz0;
    assign w_elig1    = req1_valid & ~w_haz1;
    assign w_sb_empty = ~iss_valid_q & ~(|shd_valid_q) & (outst_q == '0);

    // last_q==1 means req1 won most recently, so req0 takes the next tie.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == ST_RUN) begin
            if (w_elig0 && w_elig1) begin
                req0_ready = last_q;
                req1_ready = ~last_q;
            end else begin
                req0_ready = w_elig0;
                req1_ready = w_elig1;
            end
        end
    end

    always_comb begin
        last_d      = last_q;
        iss_valid_d = 1'b0;
        iss_rs0_d   = '0;
        iss_rs1_d   = '0;
        iss_rd_d    = '0;
        iss_op_d    = '0;
        if (req0_ready) begin
            last_d      = 1'b0;
            iss_valid_d = 1'b1;
            iss_rs0_d   = req0_rs0;
            iss_rs1_d   = req0_rs1;
            iss_rd_d    = req0_rd;
            iss_op_d    = req0_opcode;
        end else if (req1_ready) begin
            last_d      = 1'b1;
            iss_valid_d = 1'b1;
            iss_rs0_d   = req1_rs0;
            iss_rs1_d   = req1_rs1;
            iss_rd_d    = req1_rd;
            iss_op_d    = req1_opcode;
        end
    end

    always_comb begin
        shd_valid_d    = '0;
        shd_valid_d[0] = iss_valid_q;
        shd_rd_d[0]    = iss_rd_q;
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            shd_valid_d[i] = shd_valid_q[i-1];
            shd_rd_d[i]    = shd_rd_q[i-1];
        end
    end

    // An ack with nothing outstanding and nothing entering is an error; count stays 0.
    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (iss_valid_q && !ack) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!iss_valid_q && ack) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en)         state_d = ST_RUN;
            ST_RUN:   if (!en)        state_d = ST_DRAIN;
            ST_DRAIN: if (w_sb_empty) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            iss_valid_q <= 1'b0;
            iss_rs0_q   <= '0;
            iss_rs1_q   <= '0;
            iss_rd_q    <= '0;
            iss_op_q    <= '0;
            shd_valid_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) shd_rd_q[i] <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            iss_valid_q <= iss_valid_d;
            iss_rs0_q   <= iss_rs0_d;
            iss_rs1_q   <= iss_rs1_d;
            iss_rd_q    <= iss_rd_d;
            iss_op_q    <= iss_op_d;
            shd_valid_q <= shd_valid_d;
            for (int i = 0; i < FIFO_DEPTH; i++) shd_rd_q[i] <= shd_rd_d[i];
            outst_q     <= outst_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

    assign iss_valid  = iss_valid_q;
    assign iss_rs0    = iss_rs0_q;
    assign iss_rs1    = iss_rs1_q;
    assign iss_rd     = iss_rd_q;
    assign iss_opcode = iss_op_q;
    assign state      = state_q;
    assign busy       = (state_q != ST_IDLE) | ~w_sb_empty;
    assign err_ack    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_issue_arb.sv
`default_nettype none
// Testbench for riscv_issue_arb: directed vector table, hand-written corner
// sequences and a random phase, all checked against a history-queue model.
module tb_riscv_issue_arb;
    localparam int RW = 5;
    localparam int OW = 7;
    localparam int FD = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [RW-1:0] req0_rs0 = '0, req0_rs1 = '0, req0_rd = '0;
    logic [RW-1:0] req1_rs0 = '0, req1_rs1 = '0, req1_rd = '0;
    logic [OW-1:0] req0_opcode = '0, req1_opcode = '0;
    logic          req0_ready, req1_ready;
    logic          iss_valid;
    logic [RW-1:0] iss_rs0, iss_rs1, iss_rd;
    logic [OW-1:0] iss_opcode;
    logic          ack = 1'b0;
    logic [1:0]    state;
    logic          busy, err_ack;

    riscv_issue_arb #(.REG_WIDTH(RW), .OP_WIDTH(OW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req0_valid(req0_valid), .req0_rs0(req0_rs0), .req0_rs1(req0_rs1),
        .req0_rd(req0_rd), .req0_opcode(req0_opcode), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs0(req1_rs0), .req1_rs1(req1_rs1),
        .req1_rd(req1_rd), .req1_opcode(req1_opcode), .req1_ready(req1_ready),
        .iss_valid(iss_valid), .iss_rs0(iss_rs0), .iss_rs1(iss_rs1),
        .iss_rd(iss_rd), .iss_opcode(iss_opcode), .ack(ack),
        .state(state), .busy(busy), .err_ack(err_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit auto_ack = 1'b1;

    // Reference model: hist[k] is what was on the issue outputs k cycles ago.
    typedef struct { int v; int rs0; int rs1; int rd; int op; } ent_t;
    ent_t hist[$];
    int   m_state, m_out;
    bit   m_err, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        ent_t z;
        z = '{0, 0, 0, 0, 0};
        hist = {};
        for (int k = 0; k <= FD; k++) hist.push_back(z);
        m_state = 0; m_out = 0; m_err = 1'b0; m_last = 1'b1;
    endtask

    function automatic bit hazard(input int rs);
        foreach (hist[k])
            if (hist[k].v != 0 && hist[k].rd != 0 && hist[k].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_grant(output bit g0, output bit g1);
        bit e0, e1;
        e0 = req0_valid && !hazard(int'(req0_rs0)) && !hazard(int'(req0_rs1));
        e1 = req1_valid && !hazard(int'(req1_rs0)) && !hazard(int'(req1_rs1));
        g0 = 1'b0; g1 = 1'b0;
        if (m_state == 1) begin
            if (e0 && e1) begin g0 = m_last; g1 = !m_last; end
            else begin g0 = e0; g1 = e1; end
        end
    endtask

    function automatic bit m_empty();
        bit e;
        e = (m_out == 0);
        foreach (hist[k]) if (hist[k].v != 0) e = 1'b0;
        return e;
    endfunction

    task automatic m_clock();
        bit g0, g1, empty;
        ent_t n;
        m_grant(g0, g1);
        empty = m_empty();
        n = '{0, 0, 0, 0, 0};
        if (g0) begin
            n.v = 1; n.rs0 = int'(req0_rs0); n.rs1 = int'(req0_rs1);
            n.rd = int'(req0_rd); n.op = int'(req0_opcode); m_last = 1'b0;
        end else if (g1) begin
            n.v = 1; n.rs0 = int'(req1_rs0); n.rs1 = int'(req1_rs1);
            n.rd = int'(req1_rd); n.op = int'(req1_opcode); m_last = 1'b1;
        end
        if (hist[0].v != 0 && !ack) m_out++;
        else if (hist[0].v == 0 && ack) begin
            if (m_out == 0) m_err = 1'b1; else m_out--;
        end
        hist.push_front(n);
        void'(hist.pop_back());
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 2;
            default: if (empty) m_state = 0;
        endcase
    endtask

    task automatic check_all();
        bit g0, g1;
        m_grant(g0, g1);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("iss_valid", iss_valid, hist[0].v);
        chk("iss_rs0", iss_rs0, hist[0].rs0);
        chk("iss_rs1", iss_rs1, hist[0].rs1);
        chk("iss_rd", iss_rd, hist[0].rd);
        chk("iss_opcode", iss_opcode, hist[0].op);
        chk("state", state, m_state);
        chk("busy", busy, (m_state != 0) || !m_empty());
        chk("err_ack", err_ack, m_err);
    endtask

    // An ideal pipeline acks FD cycles after the instruction sat in the issue register.
    task automatic tick_pre();
        if (auto_ack) ack = (hist[FD].v != 0);
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_post();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_iss_valid"}, iss_valid, 0);
        chk({tag, "_iss_fields"}, {iss_rs0, iss_rs1, iss_rd, iss_opcode}, 0);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_ack"}, err_ack, 0);
    endtask

    typedef struct {
        int en;
        int v0, a0, b0, d0, o0;
        int v1, a1, b1, d1, o1;
        int r0, r1, iv, ird, st;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_drain;
        tbl = '{
            '{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0,  0},
            '{1, 1, 1, 2, 3, 'h33,  1, 4, 5, 6, 'h13,  1, 0, 0, 0,  1},
            '{1, 1, 1, 2, 3, 'h33,  1, 4, 5, 6, 'h13,  0, 1, 1, 3,  1},
            '{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 1, 6,  1},
            '{1, 1, 8, 9, 0, 'h33,  0, 0, 0, 0, 0,     1, 0, 0, 0,  1},
            '{1, 0, 0, 0, 0, 0,     1, 9, 0, 10, 'h13, 0, 1, 1, 0,  1},
            '{1, 1, 11, 12, 7, 'h33, 0, 0, 0, 0, 0,    1, 0, 1, 10, 1},
            '{1, 1, 7, 1, 13, 'h33, 0, 0, 0, 0, 0,     0, 0, 1, 7,  1},
            '{1, 1, 7, 1, 13, 'h33, 0, 0, 0, 0, 0,     0, 0, 0, 0,  1},
            '{1, 1, 7, 1, 13, 'h33, 0, 0, 0, 0, 0,     0, 0, 0, 0,  1},
            '{1, 1, 7, 1, 13, 'h33, 0, 0, 0, 0, 0,     0, 0, 0, 0,  1},
            '{1, 1, 7, 1, 13, 'h33, 0, 0, 0, 0, 0,     1, 0, 0, 0,  1},
            '{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 1, 13, 1}
        };

        // Power-on reset, with a request pending to show ready stays low.
        m_reset();
        req0_valid = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por_hold");
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed table: tie, round-robin, x0 and RAW stall.
        foreach (tbl[i]) begin
            en          = tbl[i].en[0];
            req0_valid  = tbl[i].v0[0];
            req0_rs0    = RW'(tbl[i].a0); req0_rs1 = RW'(tbl[i].b0);
            req0_rd     = RW'(tbl[i].d0); req0_opcode = OW'(tbl[i].o0);
            req1_valid  = tbl[i].v1[0];
            req1_rs0    = RW'(tbl[i].a1); req1_rs1 = RW'(tbl[i].b1);
            req1_rd     = RW'(tbl[i].d1); req1_opcode = OW'(tbl[i].o1);
            tick_pre();
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_iss_valid", i), iss_valid, tbl[i].iv);
            chk($sformatf("tbl%0d_iss_rd", i), iss_rd, tbl[i].ird);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            tick_post();
        end

        // Drain: three back-to-back issues, then en drops.
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_rs0 = 5'd17; req0_rs1 = 5'd18; req0_opcode = 7'h33;
        for (int k = 0; k < 3; k++) begin
            req0_rd = RW'(14 + k);
            tick_pre();
            chk("drain_issue_ready0", req0_ready, 1);
            tick_post();
        end
        en = 1'b0; req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req0_rd = 5'd20;
        saw_drain = 1'b0;
        for (int k = 0; k < 30 && state != 2'd0; k++) begin
            tick_pre();
            if (m_state == 2) begin
                saw_drain = 1'b1;
                chk("drain_no_grant", req0_ready, 0);
            end
            tick_post();
        end
        chk("drain_seen", saw_drain, 1);
        @(negedge clk);
        chk("drain_idle_state", state, 0);
        chk("drain_idle_busy", busy, 0);
        req0_valid = 1'b0;

        // Spurious ack while idle and empty sets the sticky error.
        auto_ack = 1'b0;
        @(posedge clk); #1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("err_ack_sticky", err_ack, 1);
        end

        // Mid-operation reset with two instructions in flight.
        auto_ack = 1'b1;
        en = 1'b1;
        tick();
        req0_valid = 1'b1; req0_rs0 = 5'd1; req0_rs1 = 5'd2; req0_rd = 5'd3;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rs0 = 5'd5; req1_rs1 = 5'd6; req1_rd = 5'd4;
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_rs0 = 5'd9; req0_rs1 = 5'd9; req1_rs0 = 5'd9; req1_rs1 = 5'd9;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        auto_ack = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick_pre();
        chk("post_reset_ack_err", err_ack, 1);
        tick_post();

        // Randomised traffic against the model.
        auto_ack = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            en          = ($urandom_range(0, 15) != 0);
            req0_valid  = ($urandom_range(0, 9) < 7);
            req0_rs0    = RW'($urandom_range(0, 7));
            req0_rs1    = RW'($urandom_range(0, 7));
            req0_rd     = RW'($urandom_range(0, 7));
            req0_opcode = OW'($urandom_range(0, 127));
            req1_valid  = ($urandom_range(0, 9) < 7);
            req1_rs0    = RW'($urandom_range(0, 7));
            req1_rs1    = RW'($urandom_range(0, 7));
            req1_rd     = RW'($urandom_range(0, 7));
            req1_opcode = OW'($urandom_range(0, 127));
            tick();
        end
        en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
